// File: rtl/nes_pad_if.sv
// nes_pad_if: poll, pad wires and decoded button state between a pad receiver and its consumer
interface nes_pad_if #(
  parameter int NUM_BITS = 8,
  parameter int NUM_PADS = 1
);
  logic                         poll;
  logic [NUM_PADS-1:0]          pad_data;
  logic                         pad_latch;
  logic                         pad_clk;
  logic [NUM_PADS*NUM_BITS-1:0] buttons;
  logic [NUM_PADS*NUM_BITS-1:0] press_edge;
  logic [NUM_PADS-1:0]          connected;
  logic                         valid;
  logic                         busy;
  modport master (
    output poll, pad_data,
    input  pad_latch, pad_clk, buttons, press_edge, connected, valid, busy
  );
  modport slave (
    input  poll, pad_data,
    output pad_latch, pad_clk, buttons, press_edge, connected, valid, busy
  );
endinterface

// File: rtl/nes_pad_receiver.sv
// nes_pad_receiver: polls up to two NES/SNES shift-register pads and reports button state and press edges
module nes_pad_receiver #(
  parameter int NUM_BITS     = 8,
  parameter int NUM_PADS     = 1,
  parameter int DIV_HALF     = 150,
  parameter int LATCH_CYCLES = 300
) (
  input logic      clk,
  input logic      rst_n,
  nes_pad_if.slave bus
);
  localparam int CNT_MAX = (LATCH_CYCLES > DIV_HALF) ? LATCH_CYCLES : DIV_HALF;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(NUM_BITS);
  localparam int W = NUM_PADS * NUM_BITS;
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);
  typedef enum logic [2:0] {IDLE, LATCH, SETTLE, PULSE_LO, PULSE_HI} state_t;
  state_t                       state;
  logic [CW-1:0]                cnt;
  logic [BW-1:0]                bit_idx;
  logic [NUM_PADS-1:0]          sync1;
  logic [NUM_PADS-1:0]          sync2;
  logic [NUM_PADS-1:0]          seen_hi;
  logic [NUM_PADS*(NUM_BITS-1)-1:0] sr;
  logic [NUM_PADS*(NUM_BITS-1)-1:0] sr_next;
  logic [W-1:0]                 sampled;
  logic [W-1:0]                 next_buttons;
  logic [NUM_PADS-1:0]          next_conn;
  logic                         half_done;
  assign half_done = cnt == HALF_LAST;
  // Per pad: shift the inverted current sample in at the top so the first bit ends at index 0;
  // a pad that never showed a released bit is treated as unplugged and its buttons are masked.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign sampled[p*NUM_BITS +: NUM_BITS] = {~sync2[p], sr[p*(NUM_BITS-1) +: NUM_BITS-1]};
    assign sr_next[p*(NUM_BITS-1) +: NUM_BITS-1] = sampled[p*NUM_BITS+1 +: NUM_BITS-1];
    assign next_conn[p] = seen_hi[p] | sync2[p];
    assign next_buttons[p*NUM_BITS +: NUM_BITS] = next_conn[p] ? sampled[p*NUM_BITS +: NUM_BITS] : '0;
  end
  // Two-flop synchroniser for the asynchronous pad data lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.pad_data;
      sync2 <= sync1;
    end
  end
  // Read sequencer: latch, settle, then clock pulses; the last sample commits all outputs together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      sr             <= '0;
      seen_hi        <= '0;
      bus.pad_latch  <= 1'b0;
      bus.pad_clk    <= 1'b1;
      bus.buttons    <= '0;
      bus.press_edge <= '0;
      bus.connected  <= '0;
      bus.valid      <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.poll) begin
            state    <= LATCH;
            cnt      <= '0;
            bit_idx  <= '0;
            seen_hi  <= '0;
            bus.busy <= 1'b1;
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            state         <= SETTLE;
            cnt           <= '0;
            bus.pad_latch <= 1'b0;
          end else begin
            cnt           <= cnt + 1'b1;
            bus.pad_latch <= 1'b1;
          end
        end
        SETTLE: begin
          if (half_done) begin
            state       <= PULSE_LO;
            cnt         <= '0;
            bit_idx     <= bit_idx + 1'b1;
            sr          <= sr_next;
            seen_hi     <= next_conn;
            bus.pad_clk <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PULSE_LO: begin
          if (half_done) begin
            state       <= PULSE_HI;
            cnt         <= '0;
            bus.pad_clk <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PULSE_HI: begin
          if (bus.valid) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (half_done) begin
            cnt     <= '0;
            sr      <= sr_next;
            seen_hi <= next_conn;
            if (bit_idx == BIT_LAST) begin
              bus.buttons    <= next_buttons;
              bus.press_edge <= next_buttons & ~bus.buttons;
              bus.connected  <= next_conn;
              bus.valid      <= 1'b1;
            end else begin
              state       <= PULSE_LO;
              bit_idx     <= bit_idx + 1'b1;
              bus.pad_clk <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
